// File: rtl/io_bank.sv
// Memory-mapped IO bank: GPIO out/in, free-running timer with compare match,
// sticky status flags and a 4-deep byte TX FIFO with a valid/ready sink.
module io_bank (
  input  logic        clk,
  input  logic        resetb,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam logic [5:0] WordGpioOut = 6'd0;
  localparam logic [5:0] WordGpioIn  = 6'd1;
  localparam logic [5:0] WordTimer   = 6'd2;
  localparam logic [5:0] WordCmp     = 6'd3;
  localparam logic [5:0] WordStatus  = 6'd4;
  localparam logic [5:0] WordTxData  = 6'd5;

  logic [5:0]  word;
  logic        wr;
  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] sync1_q, sync2_q;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  fifo_q [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  count_q, count_d;
  logic        fifo_empty, fifo_full;
  logic        push_req, push, pop, stat_wr;

  assign word       = io_addr[7:2];
  assign wr         = io_en & io_we;
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign stat_wr    = wr & (word == WordStatus);
  assign push_req   = wr & (word == WordTxData);
  assign pop        = tx_valid & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req & (~fifo_full | pop);

  // Outputs are forced quiet while reset is held, independent of stale state.
  assign tx_valid = resetb & ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_q[rptr_q] : 8'h00;
  assign irq      = resetb & match_q;
  assign gpio_out = gpio_out_q;

  always_comb begin
    gpio_out_d = gpio_out_q;
    cmp_d      = cmp_q;
    timer_d    = timer_q + 32'd1;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q + {2'b00, push} - {2'b00, pop};
    if (wr && word == WordGpioOut) gpio_out_d = io_data_write;
    if (wr && word == WordTimer)   timer_d    = io_data_write;
    if (wr && word == WordCmp)     cmp_d      = io_data_write;
    if (push) wptr_d = wptr_q + 2'd1;
    if (pop)  rptr_d = rptr_q + 2'd1;
    // Set wins over a same-cycle write-1-to-clear.
    match_d = (timer_q == cmp_q) | (match_q & ~(stat_wr & io_data_write[0]));
    ovf_d   = (push_req & fifo_full & ~pop) | (ovf_q & ~(stat_wr & io_data_write[6]));
  end

  always_comb begin
    io_data_read = 32'h0;
    if (io_en && !io_we) begin
      case (word)
        WordGpioOut: io_data_read = gpio_out_q;
        WordGpioIn:  io_data_read = sync2_q;
        WordTimer:   io_data_read = timer_q;
        WordCmp:     io_data_read = cmp_q;
        WordStatus:  io_data_read = {25'h0, ovf_q, count_q, fifo_empty, fifo_full, match_q};
        default:     io_data_read = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      gpio_out_q <= 32'h0;
      sync1_q    <= 32'h0;
      sync2_q    <= 32'h0;
      timer_q    <= 32'h0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      count_q    <= 3'd0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible between pointers.
  always_ff @(posedge clk) begin
    if (resetb && push) fifo_q[wptr_q] <= io_data_write[7:0];
  end

endmodule

// File: tb/tb_io_bank.sv
// Self-checking bench for io_bank: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model.
module tb_io_bank;

  logic        clk = 1'b0;
  logic        rb, en, we, rdy;
  logic [7:0]  addr;
  logic [31:0] wd, gin;
  logic [31:0] io_data_read, gpio_out;
  logic        tx_valid, irq;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_gpio, m_s1, m_s2, m_timer, m_cmp;
  logic        m_match, m_ovf;
  logic [7:0]  mq[$];

  io_bank dut (
    .clk           (clk),
    .resetb        (rb),
    .io_en         (en),
    .io_we         (we),
    .io_addr       (addr),
    .io_data_write (wd),
    .io_data_read  (io_data_read),
    .gpio_in       (gin),
    .gpio_out      (gpio_out),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (rdy),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read();
    logic [2:0] n;
    n = 3'(mq.size());
    if (!(en && !we)) return 32'h0;
    case (addr[7:2])
      6'd0:    return m_gpio;
      6'd1:    return m_s2;
      6'd2:    return m_timer;
      6'd3:    return m_cmp;
      6'd4:    return {25'h0, m_ovf, n, mq.size() == 0, mq.size() == 4, m_match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    logic v;
    v = rb && (mq.size() != 0);
    chk("rdata", io_data_read, exp_read());
    chk("gpio_out", gpio_out, m_gpio);
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, v});
    chk("tx_data", {24'h0, tx_data}, v ? {24'h0, mq[0]} : 32'h0);
    chk("irq", {31'h0, irq}, {31'h0, rb && m_match});
  endtask

  task automatic model_step();
    logic w_en, pop, push_req, nm, no;
    logic [5:0] w;
    if (!rb) begin
      m_gpio = 0; m_s1 = 0; m_s2 = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
      m_match = 0; m_ovf = 0; mq.delete();
    end else begin
      w_en     = en && we;
      w        = addr[7:2];
      pop      = (mq.size() != 0) && rdy;
      push_req = w_en && w == 6'd5;
      nm = (m_timer == m_cmp) || (m_match && !(w_en && w == 6'd4 && wd[0]));
      no = (push_req && mq.size() == 4 && !pop) || (m_ovf && !(w_en && w == 6'd4 && wd[6]));
      if (pop) void'(mq.pop_front());
      if (push_req && mq.size() < 4) mq.push_back(wd[7:0]);
      m_match = nm;
      m_ovf   = no;
      m_timer = (w_en && w == 6'd2) ? wd : m_timer + 1;
      if (w_en && w == 6'd3) m_cmp = wd;
      if (w_en && w == 6'd0) m_gpio = wd;
      m_s2 = m_s1;
      m_s1 = gin;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    en = 1; we = 1; addr = a; wd = d;
    cycle();
    en = 0; we = 0;
  endtask

  task automatic rd_now(input string tag, input logic [7:0] a, input logic [31:0] exp);
    en = 1; we = 0; addr = a;
    #1;
    chk(tag, io_data_read, exp);
  endtask

  initial begin
    rb = 0; en = 0; we = 0; rdy = 0; addr = 0; wd = 0; gin = 0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1;
    end
    cycle();
    rb = 1;
    rd_now("rst_cmp", 8'h0C, 32'hFFFF_FFFF);
    rd_now("rst_status", 8'h10, 32'h0000_0004);
    en = 0;

    // GPIO_OUT write and same-cycle read
    wr(8'h00, 32'hA5A5_0F0F);
    chk("gpio_lit", gpio_out, 32'hA5A5_0F0F);
    rd_now("gpio_rd", 8'h00, 32'hA5A5_0F0F);
    cycle();

    // Timer wrap and compare match
    wr(8'h0C, 32'h0000_0001);
    wr(8'h08, 32'hFFFF_FFFE);
    rd_now("tmr0", 8'h08, 32'hFFFF_FFFE); cycle();
    rd_now("tmr1", 8'h08, 32'hFFFF_FFFF); cycle();
    rd_now("tmr2", 8'h08, 32'h0000_0000); cycle();
    rd_now("tmr3", 8'h08, 32'h0000_0001); cycle();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_now("match_rd", 8'h10, 32'h0000_0005);
    wr(8'h10, 32'h0000_0001);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // Overflow on a full FIFO, then drain
    rdy = 0;
    wr(8'h14, 32'h11); wr(8'h14, 32'h22); wr(8'h14, 32'h33);
    wr(8'h14, 32'h44); wr(8'h14, 32'h55);
    rd_now("full_ovf", 8'h10, 32'h0000_0062);
    en = 0; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain", {24'h0, tx_data}, 32'h11 * (i + 1));
      cycle();
    end
    chk("drained", {31'h0, tx_valid}, 32'h0);
    wr(8'h10, 32'h0000_0040);

    // Push into full FIFO with simultaneous pop
    rdy = 0;
    wr(8'h14, 32'hA1); wr(8'h14, 32'hA2); wr(8'h14, 32'hA3); wr(8'h14, 32'hA4);
    rdy = 1;
    wr(8'h14, 32'h66);
    rdy = 0;
    rd_now("full_pop", 8'h10, 32'h0000_0022);
    en = 0; rdy = 1;
    repeat (3) cycle();
    chk("last66", {24'h0, tx_data}, 32'h66);
    cycle();
    rdy = 0;

    // Input synchronizer latency
    gin = 32'h1234_5678;
    rd_now("sync0", 8'h04, 32'h0); cycle();
    rd_now("sync1", 8'h04, 32'h0); cycle();
    rd_now("sync2", 8'h04, 32'h1234_5678); cycle();
    rd_now("unmapped", 8'h40, 32'h0); cycle();
    en = 0;

    // Mid-operation reset
    wr(8'h14, 32'h01); wr(8'h14, 32'h02); wr(8'h14, 32'h03);
    wr(8'h08, 32'h0000_0100);
    rb = 0;
    wr(8'h00, 32'hDEAD_BEEF);
    rb = 1;
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_gpio", gpio_out, 32'h0);
    rd_now("rst_tmr", 8'h08, 32'h0);
    rd_now("rst_cmp2", 8'h0C, 32'hFFFF_FFFF);
    rd_now("rst_cnt", 8'h10, 32'h0000_0004);
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      rb  = ($urandom_range(0, 199) != 0);
      en  = $urandom_range(0, 1);
      we  = $urandom_range(0, 1);
      r   = $urandom_range(0, 11);
      if (r < 6) addr = 8'(r * 4 + $urandom_range(0, 3));
      else if (r < 9) addr = 8'h14;
      else addr = 8'($urandom_range(0, 255));
      wd  = $urandom;
      if (addr[7:2] == 6'd3 && $urandom_range(0, 1) == 1)
        wd = m_timer + 32'($urandom_range(2, 10));
      if ($urandom_range(0, 7) == 0) gin = $urandom;
      rdy = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
